// File: rtl/d_sram_bridge_pkg.sv
// Shared definitions for the MEM-stage to SRAM-like data bus bridge:
// FSM state encoding, access size codes and MIPS fixed-mapping segment bases.
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;

  // True when the top three address bits select kseg0 or kseg1.
  function automatic logic is_fixmap_seg(input logic [2:0] top_bits);
    return (top_bits == KSEG0_BASE[31:29]) || (top_bits == KSEG1_BASE[31:29]);
  endfunction

endpackage

// File: rtl/d_sram_bridge_addr_map.sv
// d_addr_map: combinational MIPS fixed mapper. kseg0/kseg1 addresses have
// their top three bits cleared; every other address passes through.
module d_addr_map
  import d_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] mapped_addr
);

  // Clear the segment bits only for the unmapped kernel segments.
  always_comb begin
    mapped_addr = addr;
    if (is_fixmap_seg(addr[ADDR_W-1 -: 3])) begin
      mapped_addr[ADDR_W-1 -: 3] = 3'b000;
    end
  end

endmodule

// File: rtl/d_sram_bridge.sv
// d_sram_bridge: issues the MEM-stage data access onto a split-transaction
// SRAM-like bus, stalls the pipeline until data_ok and holds the result while
// other stall sources keep the pipeline frozen, so nothing is issued twice.
// Optional macro D_SRAM_BRIDGE_FIXMAP_EN enables MIPS fixed address mapping.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata_last,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [1:0]            mem_size,
  input  logic [31:0]           mem_excepttype,
  input  logic                  stallreq_from_if,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  stallreq_from_mem,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W/8-1:0]   data_wstrb,
  input  logic                  data_addr_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  input  logic                  data_data_ok
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_reg, state_next;
  logic                req_we_reg;
  logic [1:0]          req_size_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [DATA_W-1:0]   req_wdata_reg;
  logic [STRB_W-1:0]   req_sel_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic                acc_v;
  logic                bus_we;
  logic [1:0]          bus_size;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [STRB_W-1:0]   bus_sel;

  assign acc_v = mem_en & (mem_excepttype == 32'd0);

  // State register; reset also abandons any outstanding bus transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture request attributes in the issue cycle so ADDR holds them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_we_reg    <= 1'b0;
      req_size_reg  <= 2'd0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_sel_reg   <= '0;
    end else if (state_reg == ST_IDLE && acc_v) begin
      req_we_reg    <= mem_we;
      req_size_reg  <= mem_size;
      req_addr_reg  <= mem_addr;
      req_wdata_reg <= mem_wdata_last;
      req_sel_reg   <= sel;
    end
  end

  // Keep the completed response (stores too) for the HOLD period and later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (state_reg == ST_DATA && data_data_ok) begin
      rdata_reg <= data_rdata;
    end
  end

  // Next-state, request and stall decode; IDLE issues straight from the inputs.
  always_comb begin
    state_next        = state_reg;
    data_req          = 1'b0;
    stallreq_from_mem = 1'b0;
    bus_we            = 1'b0;
    bus_size          = 2'd0;
    bus_addr          = '0;
    bus_wdata         = '0;
    bus_sel           = '0;
    case (state_reg)
      ST_IDLE: begin
        if (acc_v) begin
          data_req          = 1'b1;
          stallreq_from_mem = 1'b1;
          bus_we            = mem_we;
          bus_size          = mem_size;
          bus_addr          = mem_addr;
          bus_wdata         = mem_wdata_last;
          bus_sel           = sel;
          state_next        = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        data_req          = 1'b1;
        stallreq_from_mem = 1'b1;
        bus_we            = req_we_reg;
        bus_size          = req_size_reg;
        bus_addr          = req_addr_reg;
        bus_wdata         = req_wdata_reg;
        bus_sel           = req_sel_reg;
        if (data_addr_ok) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        stallreq_from_mem = ~data_data_ok;
        bus_we            = req_we_reg;
        bus_size          = req_size_reg;
        bus_addr          = req_addr_reg;
        bus_wdata         = req_wdata_reg;
        bus_sel           = req_sel_reg;
        if (data_data_ok) begin
          state_next = stallreq_from_if ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!stallreq_from_if) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data_wr    = bus_we;
  assign data_size  = bus_size;
  assign data_wdata = bus_wdata;
  assign mem_rdata  = (state_reg == ST_DATA && data_data_ok) ? data_rdata : rdata_reg;

  // Strobes are only meaningful for writes; reads present all-zero lanes.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
    assign data_wstrb[gi] = bus_we & bus_sel[gi];
  end

`ifdef D_SRAM_BRIDGE_FIXMAP_EN
  d_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .addr        (bus_addr),
    .mapped_addr (data_addr)
  );
`else
  assign data_addr = bus_addr;
`endif

endmodule
